// File: rtl/pipe_stage_skid.sv
// -----------------------------------------------------------------------------
// pipe_stage_skid
//   Generic pipeline stage register that moves a datapath payload and its
//   control bundle between two adjacent stages using a valid/ready handshake.
//   Supports stall, flush and bubble insertion. When no entry is presented the
//   control bundle reads as all-zero so the downstream stage sees a NOP.
//   With SKID=1 a 2-entry skid buffer lets in_ready come straight from a flop,
//   which breaks the ready path between stages. With SKID=0 the stage holds a
//   single entry and in_ready is combinational.
//
// Parameters
//   DATA_W  payload width
//   CTRL_W  control-bundle width
//   SKID    1 = 2-entry skid buffer, registered in_ready; 0 = single entry
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous reset, active-high
//   in_valid   in   upstream holds a valid payload
//   in_ready   out  stage can accept this cycle
//   in_data    in   upstream payload
//   in_ctrl    in   upstream control bundle
//   flush      in   synchronous kill of every held entry
//   out_valid  out  out_data/out_ctrl are valid
//   out_ready  in   downstream accepts (0 = stall)
//   out_data   out  head-entry payload (holds last value when idle)
//   out_ctrl   out  head-entry control, zero whenever out_valid=0
//   bubble_cnt out  cycles with out_valid=0 since reset, saturating
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module pipe_stage_skid #(
  parameter int unsigned DATA_W = 140,
  parameter int unsigned CTRL_W = 9,
  parameter int unsigned SKID   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [15:0]       bubble_cnt
);

  // Occupancy of the stage: main is the head register, skid the overflow.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                ready_q, ready_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   main_data_q, main_data_d;
  logic [CTRL_W-1:0]   main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0]   skid_data_q, skid_data_d;
  logic [CTRL_W-1:0]   skid_ctrl_q, skid_ctrl_d;
  logic [15:0]         bubble_cnt_q, bubble_cnt_d;

  logic push;
  logic pop;

  // ready_q is 0 in reset and rises on the first edge after it, so it both
  // blocks input during reset and, in skid mode, is the whole of in_ready.
  // In single-entry mode the head can be replaced in the cycle it is popped.
  assign in_ready = (SKID != 0) ? ready_q
                                : (ready_q & (~out_valid_q | out_ready));

  assign push = in_valid & in_ready;
  assign pop  = out_valid_q & out_ready;

  // Next-state: flush wins over everything and drops any input accepted in
  // the same cycle. The ONE->TWO transition is only reachable with SKID=1,
  // because in single-entry mode a push into a full stage implies a pop.
  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;

    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (push) begin
            state_d     = ST_ONE;
            main_data_d = in_data;
            main_ctrl_d = in_ctrl;
          end
        end
        ST_ONE: begin
          if (push && pop) begin
            main_data_d = in_data;
            main_ctrl_d = in_ctrl;
          end else if (push && !pop) begin
            state_d     = ST_TWO;
            skid_data_d = in_data;
            skid_ctrl_d = in_ctrl;
          end else if (!push && pop) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          // in_ready is low here, so only a pop can happen; the overflow
          // entry slides into the head on the same edge.
          if (pop) begin
            state_d     = ST_ONE;
            main_data_d = skid_data_q;
            main_ctrl_d = skid_ctrl_q;
          end
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end

    ready_d     = (state_d != ST_TWO);
    out_valid_d = (state_d != ST_EMPTY);
  end

  // Bubble counter counts idle output cycles and sticks at all-ones.
  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (!out_valid_q && (bubble_cnt_q != 16'hFFFF)) begin
      bubble_cnt_d = bubble_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_EMPTY;
      ready_q      <= 1'b0;
      out_valid_q  <= 1'b0;
      main_data_q  <= '0;
      main_ctrl_q  <= '0;
      skid_data_q  <= '0;
      skid_ctrl_q  <= '0;
      bubble_cnt_q <= 16'd0;
    end else begin
      state_q      <= state_d;
      ready_q      <= ready_d;
      out_valid_q  <= out_valid_d;
      main_data_q  <= main_data_d;
      main_ctrl_q  <= main_ctrl_d;
      skid_data_q  <= skid_data_d;
      skid_ctrl_q  <= skid_ctrl_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  // Idle output presents a NOP control bundle; the payload simply holds.
  assign out_valid  = out_valid_q;
  assign out_data   = main_data_q;
  assign out_ctrl   = out_valid_q ? main_ctrl_q : '0;
  assign bubble_cnt = bubble_cnt_q;

endmodule
